// File: rtl/rlc_filter_pkg.sv
// Shared types, coefficient addresses and fixed-point helpers for the
// multi-channel second-order state-space filter.
package rlc_filter_pkg;

  // Serial controller: one accept cycle followed by two MAC cycles.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC1 = 2'd1,
    CALC2 = 2'd2
  } state_t;

  // Coefficient register map; addresses 6 and 7 are unused.
  localparam logic [2:0] CFG_A11 = 3'd0;
  localparam logic [2:0] CFG_A12 = 3'd1;
  localparam logic [2:0] CFG_A21 = 3'd2;
  localparam logic [2:0] CFG_A22 = 3'd3;
  localparam logic [2:0] CFG_B1  = 3'd4;
  localparam logic [2:0] CFG_B2  = 3'd5;
  localparam int NUM_COEF = 6;

  // Container width for the saturating helper; wide enough for any
  // accumulator of 2*WIDTH+2 bits with WIDTH up to 31.
  localparam int ACC_W = 64;

  // Arithmetic right shift (floor) followed by saturation to a signed
  // range of 'width' bits. Result is returned sign-extended to ACC_W.
  function automatic logic signed [ACC_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] acc,
    input int                      frac,
    input int                      width
  );
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    shifted = acc >>> frac;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v) begin
      sat_shift = max_v;
    end else if (shifted < min_v) begin
      sat_shift = min_v;
    end else begin
      sat_shift = shifted;
    end
  endfunction

endpackage

// File: rtl/rlc_filter_mc_if.sv
// Sample, clear, coefficient and result signals of the filter bundled
// into one interface. The master side is the sample source/consumer.
interface rlc_filter_mc_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 18
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [WIDTH-1:0]  in_data;

  logic                     clr_valid;
  logic [CH_W-1:0]          clr_ch;

  logic                     cfg_we;
  logic [2:0]               cfg_addr;
  logic signed [WIDTH-1:0]  cfg_data;

  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [WIDTH-1:0]  out_data;
  logic signed [WIDTH-1:0]  out_aux;

  modport master (
    output in_valid, in_ch, in_data, clr_valid, clr_ch,
    output cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_ch, out_data, out_aux
  );

  modport slave (
    input  in_valid, in_ch, in_data, clr_valid, clr_ch,
    input  cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_ch, out_data, out_aux
  );

endinterface

// File: rtl/rlc_mac3.sv
// Combinational three-term signed multiply-accumulate with a floor shift
// by FRAC and saturation back to WIDTH bits. Products are full width and
// the sum carries two guard bits, so nothing overflows before saturation.
module rlc_mac3 #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 12
) (
  input  logic signed [WIDTH-1:0] coef [3],
  input  logic signed [WIDTH-1:0] opnd [3],
  output logic signed [WIDTH-1:0] y
);
  import rlc_filter_pkg::*;

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = 2 * WIDTH + 2;

  logic signed [PROD_W-1:0] prod [3];
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sat_full;

  for (genvar gi = 0; gi < 3; gi++) begin : g_prod
    assign prod[gi] = PROD_W'(coef[gi]) * PROD_W'(opnd[gi]);
  end

  // Accumulate the three products, then shift and clamp.
  always_comb begin
    sum      = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]);
    sat_full = sat_shift(ACC_W'(sum), FRAC, WIDTH);
    y        = sat_full[WIDTH-1:0];
  end

endmodule

// File: rtl/rlc_filter_mc.sv
// Multi-channel second-order state-space filter. Each channel keeps an
// inductor current x1 and capacitor voltage x2; one accepted sample runs
// x[k+1] = A*x[k] + B*u[k] over two cycles through a single shared MAC.
module rlc_filter_mc #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 18,
  parameter int FRAC   = 12
) (
  input logic           clk,
  input logic           rst,
  rlc_filter_mc_if.slave bus
);
  import rlc_filter_pkg::*;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // One extra bit so the range test also works when NUM_CH is a power of 2.
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  state_t state_reg, state_next;

  logic signed [WIDTH-1:0] coef_reg [NUM_COEF];
  logic signed [WIDTH-1:0] snap_reg [NUM_COEF];
  logic signed [WIDTH-1:0] x1_mem   [NUM_CH];
  logic signed [WIDTH-1:0] x2_mem   [NUM_CH];

  logic signed [WIDTH-1:0] u_reg, x1_reg, x2_reg, x1n_reg;
  logic [CH_W-1:0]         ch_reg;
  logic                    ch_ok_reg;

  logic                    out_valid_reg;
  logic [CH_W-1:0]         out_ch_reg;
  logic signed [WIDTH-1:0] out_data_reg, out_aux_reg;

  logic                    in_ready, accept, clr_hit, in_ok, clr_ok, wr_en;
  logic signed [WIDTH-1:0] mac_coef [3];
  logic signed [WIDTH-1:0] mac_opnd [3];
  logic signed [WIDTH-1:0] mac_y;

  assign in_ok  = {1'b0, bus.in_ch}  < NUM_CH_L;
  assign clr_ok = {1'b0, bus.clr_ch} < NUM_CH_L;
  assign wr_en  = (state_reg == CALC2) && ch_ok_reg;

  // Next-state, handshake and MAC operand selection.
  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    accept      = 1'b0;
    clr_hit     = 1'b0;
    mac_coef[0] = snap_reg[CFG_A11];
    mac_coef[1] = snap_reg[CFG_A12];
    mac_coef[2] = snap_reg[CFG_B1];
    mac_opnd[0] = x1_reg;
    mac_opnd[1] = x2_reg;
    mac_opnd[2] = u_reg;
    case (state_reg)
      IDLE: begin
        in_ready = !bus.clr_valid;
        if (bus.clr_valid) begin
          clr_hit = clr_ok;
        end else if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = CALC1;
        end
      end
      CALC1: state_next = CALC2;
      CALC2: begin
        mac_coef[0] = snap_reg[CFG_A21];
        mac_coef[1] = snap_reg[CFG_A22];
        mac_coef[2] = snap_reg[CFG_B2];
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register; reset aborts any computation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  rlc_mac3 #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .coef (mac_coef),
    .opnd (mac_opnd),
    .y    (mac_y)
  );

  // Coefficient registers are writable in any state.
  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef
    // Write one coefficient when its address is strobed.
    always_ff @(posedge clk) begin
      if (rst) begin
        coef_reg[gi] <= '0;
      end else if (bus.cfg_we && bus.cfg_addr == 3'(gi)) begin
        coef_reg[gi] <= bus.cfg_data;
      end
    end
  end

  // Per-channel state; a clear only happens in IDLE, so it never races
  // the write-back of the channel in flight.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_state
    // Clear or write back the two states of one channel.
    always_ff @(posedge clk) begin
      if (rst) begin
        x1_mem[gi] <= '0;
        x2_mem[gi] <= '0;
      end else if (clr_hit && bus.clr_ch == CH_W'(gi)) begin
        x1_mem[gi] <= '0;
        x2_mem[gi] <= '0;
      end else if (wr_en && ch_reg == CH_W'(gi)) begin
        x1_mem[gi] <= x1n_reg;
        x2_mem[gi] <= mac_y;
      end
    end
  end

  // Operand capture on accept, x1n in CALC1, result registers in CALC2.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_reg         <= '0;
      x1_reg        <= '0;
      x2_reg        <= '0;
      x1n_reg       <= '0;
      ch_reg        <= '0;
      ch_ok_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_data_reg  <= '0;
      out_aux_reg   <= '0;
      for (int i = 0; i < NUM_COEF; i++) snap_reg[i] <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      if (accept) begin
        u_reg     <= bus.in_data;
        ch_reg    <= bus.in_ch;
        ch_ok_reg <= in_ok;
        x1_reg    <= in_ok ? x1_mem[bus.in_ch] : '0;
        x2_reg    <= in_ok ? x2_mem[bus.in_ch] : '0;
        for (int i = 0; i < NUM_COEF; i++) snap_reg[i] <= coef_reg[i];
      end
      if (state_reg == CALC1) begin
        x1n_reg <= mac_y;
      end
      if (wr_en) begin
        out_valid_reg <= 1'b1;
        out_ch_reg    <= ch_reg;
        out_data_reg  <= mac_y;
        out_aux_reg   <= x1n_reg;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_aux   = out_aux_reg;

endmodule

// File: tb/tb_rlc_filter_mc.sv
// Directed bench for rlc_filter_mc. A 4-channel and a 3-channel instance
// receive identical stimulus; the 3-channel one covers out-of-range ids.
module tb_rlc_filter_mc;
  import rlc_filter_pkg::*;

  localparam int WIDTH = 18;
  localparam int FRAC  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid  = 1'b0;
  logic [1:0]        in_ch     = '0;
  logic signed [17:0] in_data  = '0;
  logic              clr_valid = 1'b0;
  logic [1:0]        clr_ch    = '0;
  logic              cfg_we    = 1'b0;
  logic [2:0]        cfg_addr  = '0;
  logic signed [17:0] cfg_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  bit last_v3 = 1'b0;

  rlc_filter_mc_if #(.NUM_CH(4), .WIDTH(WIDTH)) bus4 ();
  rlc_filter_mc_if #(.NUM_CH(3), .WIDTH(WIDTH)) bus3 ();

  assign bus4.in_valid  = in_valid;
  assign bus4.in_ch     = in_ch;
  assign bus4.in_data   = in_data;
  assign bus4.clr_valid = clr_valid;
  assign bus4.clr_ch    = clr_ch;
  assign bus4.cfg_we    = cfg_we;
  assign bus4.cfg_addr  = cfg_addr;
  assign bus4.cfg_data  = cfg_data;
  assign bus3.in_valid  = in_valid;
  assign bus3.in_ch     = in_ch;
  assign bus3.in_data   = in_data;
  assign bus3.clr_valid = clr_valid;
  assign bus3.clr_ch    = clr_ch;
  assign bus3.cfg_we    = cfg_we;
  assign bus3.cfg_addr  = cfg_addr;
  assign bus3.cfg_data  = cfg_data;

  rlc_filter_mc #(.NUM_CH(4), .WIDTH(WIDTH), .FRAC(FRAC)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );
  rlc_filter_mc #(.NUM_CH(3), .WIDTH(WIDTH), .FRAC(FRAC)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data[17:0];
    @(negedge clk);
    cfg_we   = 1'b0;
    $display("cfg addr=%0d data=%0d", addr, data);
  endtask

  // One sample; optional coefficient write in the cycle after accept.
  task automatic send(input string tag, input int ch, input int u,
                      input int exp_aux, input int exp_data,
                      input bit mid_we = 1'b0, input logic [2:0] mid_addr = 3'd0,
                      input int mid_data = 0);
    int w = 0;
    int k = 1;
    last_v3 = 1'b0;
    while (!bus4.in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_ch    = ch[1:0];
    in_data  = u[17:0];
    @(negedge clk);
    in_valid = 1'b0;
    if (mid_we) begin
      cfg_we   = 1'b1;
      cfg_addr = mid_addr;
      cfg_data = mid_data[17:0];
    end
    while (!bus4.out_valid && k < 8) begin
      @(negedge clk);
      cfg_we = 1'b0;
      k++;
      if (bus3.out_valid) last_v3 = 1'b1;
    end
    cfg_we = 1'b0;
    $display("txn %s ch=%0d u=%0d -> aux=%0d data=%0d ch=%0d lat=%0d",
             tag, ch, u, bus4.out_aux, bus4.out_data, bus4.out_ch, k);
    check({tag, ".lat"},   k, 3);
    check({tag, ".aux"},   bus4.out_aux, exp_aux);
    check({tag, ".data"},  bus4.out_data, exp_data);
    check({tag, ".ch"},    bus4.out_ch, ch);
    check({tag, ".ready"}, bus4.in_ready, 1);
    @(negedge clk);
    check({tag, ".pulse"}, bus4.out_valid, 0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset release");
    check("rst.out_valid", bus4.out_valid, 0);
    check("rst.out_ch",    bus4.out_ch, 0);
    check("rst.out_data",  bus4.out_data, 0);
    check("rst.out_aux",   bus4.out_aux, 0);
    check("rst.in_ready",  bus4.in_ready, 1);

    // Reset during CALC1 must abort with no output and no write-back.
    cfg(CFG_A11, 4096);
    cfg(CFG_B1, 4096);
    in_valid = 1'b1; in_ch = 2'd2; in_data = 18'sd100;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus4.out_valid) cnt++;
    end
    $display("txn reset mid-CALC1 out_valid pulses=%0d", cnt);
    check("rstmid.no_out", cnt, 0);
    check("rstmid.ready", bus4.in_ready, 1);
    send("zero_coef", 0, 100, 0, 0);

    // Integrator coefficients.
    cfg(CFG_A11, 4096);
    cfg(CFG_A12, 0);
    cfg(CFG_A21, 4096);
    cfg(CFG_A22, 4096);
    cfg(CFG_B1, 4096);
    cfg(CFG_B2, 0);
    send("integ1", 2, 100, 100, 0);
    send("integ2", 2, 100, 200, 100);
    send("integ3", 2, 100, 300, 300);
    send("iso_ch0", 0, 50, 50, 0);
    send("iso_ch2", 2, 100, 400, 600);

    // Saturation on ch1.
    send("sat1", 1, 100000, 100000, 0);
    send("sat2", 1, 100000, 131071, 100000);
    send("sat3", 1, -131072, -1, 131071);
    send("sat4", 1, -131072, -131072, 131070);

    // B1 = 0.5: -1.5 must floor to -2.
    cfg(CFG_B1, 2048);
    send("floor", 3, -3, -2, 0);
    cfg(CFG_B1, 4096);

    // Clear wins over a simultaneous sample.
    clr_valid = 1'b1; clr_ch = 2'd2;
    in_valid = 1'b1; in_ch = 2'd2; in_data = 18'sd77;
    #1;
    check("clr.in_ready", bus4.in_ready, 0);
    @(negedge clk);
    clr_valid = 1'b0;
    in_valid  = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus4.out_valid) cnt++;
    end
    $display("txn clear ch2 with concurrent sample, pulses=%0d", cnt);
    check("clr.no_out", cnt, 0);
    send("after_clr", 2, 10, 10, 0);

    // ch3 is legal on the 4-channel DUT, out of range on the 3-channel one.
    send("oor", 3, 100, 98, -2);
    check("oor.dut3_valid", last_v3, 0);
    check("oor.dut3_aux",   bus3.out_aux, 10);
    check("oor.dut3_ready", bus3.in_ready, 1);

    // Coefficient write during CALC1 affects only the next sample.
    send("snap1", 0, 100, 150, 50, 1'b1, CFG_B1, 8192);
    send("snap2", 0, 100, 350, 200);
    check("snap.dut3_aux", bus3.out_aux, 350);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rlc_filter_mc.md
# rlc_filter_mc

Parametrised, multi-channel, synthesizable second-order (RLC-type) discrete-time state-space filter in signed fixed point. Each channel holds two states, inductor current x1 and capacitor voltage x2, advanced by x[k+1] = A·x[k] + B·u[k] with run-time programmable coefficients. It is the hardware successor to the single-channel real-valued RLC model wrapper and sits between a sample source and a downstream consumer in the analog-model emulation datapath.

## Interface
- NUM_CH, 4: number of independent channels (≥1); channel index width CH_W = max(1, $clog2(NUM_CH)).
- WIDTH, 18: signed width of samples, states and coefficients.
- FRAC, 12: fractional bits of every operand; 1.0 = 2^FRAC.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample or a clear this cycle.
- in_ch  in  CH_W  channel of input sample.
- in_data  in  WIDTH  u[k], signed.
- clr_valid  in  1  request to zero both states of clr_ch.
- clr_ch  in  CH_W  channel to clear.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  3  0=A11, 1=A12, 2=A21, 3=A22, 4=B1, 5=B2; 6–7 ignored.
- cfg_data  in  WIDTH  coefficient value, signed.
- out_valid  out  1  one-cycle pulse, result present.
- out_ch  out  CH_W  channel of result.
- out_data  out  WIDTH  new x2 (capacitor voltage).
- out_aux  out  WIDTH  new x1 (inductor current).

## Operation
- FSM states IDLE, CALC1, CALC2; reset state IDLE.
- in_ready = (state==IDLE) && !clr_valid.
- In IDLE: clr_valid has priority. clear zeroes x1/x2 of clr_ch at that edge and produces no output. Otherwise, in_valid && in_ready accepts: latch u, ch, x1[ch], x2[ch], and snapshot all six coefficients. Move to CALC1.
- CALC1: x1n = sat((A11·x1 + A12·x2 + B1·u) >>> FRAC). Go to CALC2.
- CALC2: x2n = sat((A21·x1 + A22·x2 + B2·u) >>> FRAC), using latched old x1, not x1n. Write x1n/x2n to channel, register outputs. Go to IDLE.
- Arithmetic: products 2·WIDTH signed, sum WIDTH·2+2 bits, no intermediate overflow. Arithmetic shift truncates toward −inf. Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- cfg_we writes the coefficient register in any state. The in-flight computation uses the snapshot, so a write takes effect from the next accepted sample.
- Out-of-range in_ch or clr_ch (≥NUM_CH): request is consumed (handshake completes) but has no effect, and no out_valid is produced.
- No output backpressure: the consumer must take out_valid pulses.
- Reset (any state, including mid-computation) aborts the operation. Reset zeroes all states and coefficients.
- Output values after reset: out_valid=0, out_ch=0, out_data=0, out_aux=0. in_ready=1 once rst is low and clr_valid is low.

## Timing
- Accept at edge ending cycle T. CALC1 during T+1, CALC2 during T+2. States and outputs update at edge ending T+2.
- out_valid is high during T+3 only. out_ch/out_data/out_aux hold until the next result.
- in_ready is high again in T+3, giving a throughput of one sample per 3 cycles.
- A clear completes in one cycle. A sample to the same channel accepted in the next cycle sees zero states.
- Same-channel back-to-back samples use the state written by the previous operation (no hazard, since the FSM is serial).

## Structure
- Package rlc_filter_pkg holds:
  - FSM state enum;
  - cfg address localparams;
  - signed saturate-and-shift function, parametrised through a function argument or a width localparam.
- Sub-module rlc_mac3 is a combinational 3-term signed multiply-accumulate with shift and saturation. It is instanced once and reused in CALC1/CALC2 via operand muxes.
- State storage: two register arrays [NUM_CH][WIDTH]; no RAM inference required.

## Test plan
All scenarios use WIDTH=18, FRAC=12, NUM_CH=4.
- **Reset:** check all outputs are 0 and in_ready=1. Assert rst mid-CALC1, then check no out_valid is produced and a subsequent sample sees zero state.
- **Integrator:** set A11=A22=A21=4096, A12=0, B1=4096, B2=0. Send u=100 on ch2 three times. Expect (out_aux, out_data) = (100,0), (200,100), (300,300), each with out_valid exactly 3 cycles after accept.
- **Channel isolation:** after the integrator run, send u=50 on ch0. Expect (50,0), with ch2 states unchanged (next ch2 sample gives 400/600).
- **Saturation:** set A11=4096, B1=4096. Send u=100000 twice on ch1. Expect out_aux 100000 then 131071. Send u=−131072 twice; expect x1 saturates to −131072.
- **Clear priority:** assert clr_valid(ch2) and in_valid together. Expect in_ready=0 and ch2 zeroed. Next u=10 on ch2 gives (10,0).
- **Config snapshot:** change B1 to 8192 in the cycle after accept. Expect the current result to use 4096 and the next to use 8192. Also check that out-of-range in_ch=5 is not possible (CH_W=2); instead test NUM_CH=3 with in_ch=3 and expect no out_valid.
